// File: rtl/bell_pkg.sv
// Shared FSM encoding and default parameters for the bell judge.
package bell_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JUDGE   = 2'd1,
    LOCKOUT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned DEF_N_PLAYERS  = 4;
  localparam int unsigned DEF_SCORE_W    = 8;
  localparam int unsigned DEF_COLOR_W    = 2;
  localparam int unsigned DEF_NUM_W      = 3;
  localparam int unsigned DEF_TARGET     = 5;
  localparam int unsigned DEF_WIN_MARGIN = 10;
  localparam int unsigned DEF_LOCK_CYC   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [$clog2(N)-1:0]      ptr,
  output logic [N-1:0]              gnt
);

  localparam int unsigned PTR_W = $clog2(N);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = PTR_W'((int'(ptr) + k) % int'(N));
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_bell_judge.sv
// Judge for a multi-player bell game: arbitrates presses, checks the cards,
// keeps saturating signed scores and declares a leader / game over.
module multi_bell_judge
  import bell_pkg::*;
#(
  parameter int unsigned N_PLAYERS  = DEF_N_PLAYERS,
  parameter int unsigned SCORE_W    = DEF_SCORE_W,
  parameter int unsigned COLOR_W    = DEF_COLOR_W,
  parameter int unsigned NUM_W      = DEF_NUM_W,
  parameter int unsigned TARGET     = DEF_TARGET,
  parameter int unsigned WIN_MARGIN = DEF_WIN_MARGIN,
  parameter int unsigned LOCK_CYC   = DEF_LOCK_CYC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PLAYERS-1:0]           bell_req,
  input  logic [N_PLAYERS*COLOR_W-1:0]   card_color,
  input  logic [N_PLAYERS*NUM_W-1:0]     card_num,
  input  logic [SCORE_W-1:0]             pot,
  output logic [N_PLAYERS*SCORE_W-1:0]   score,
  output logic [N_PLAYERS-1:0]           grant,
  output logic                           judged,
  output logic                           correct,
  output logic [N_PLAYERS-1:0]           leader,
  output logic                           game_over,
  output logic                           busy
);

  localparam int unsigned PTR_W    = $clog2(N_PLAYERS);
  localparam int unsigned N_COLORS = 1 << COLOR_W;
  localparam int unsigned SUM_W    = $clog2(N_PLAYERS * ((1 << NUM_W) - 1) + 1);
  localparam int unsigned LOCK_W   = $clog2(LOCK_CYC + 1);
  localparam int unsigned EXT_W    = SCORE_W + 2;
  localparam int unsigned CMP_W    = SCORE_W + 1;

  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((1 << (SCORE_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic signed [EXT_W-1:0] ONE    = EXT_W'(1);
  localparam logic signed [CMP_W-1:0] MARGIN = CMP_W'(WIN_MARGIN);

  state_t                    state, state_d;
  logic [PTR_W-1:0]          ptr, ptr_d, gidx, gidx_d, gidx_c;
  logic [LOCK_W-1:0]         lock_cnt, lock_d;
  logic signed [SCORE_W-1:0] score_q [N_PLAYERS];
  logic signed [SCORE_W-1:0] score_d [N_PLAYERS];
  logic [SCORE_W-1:0]        pot_q, pot_d;
  logic [N_PLAYERS-1:0]      grant_d, gnt_c, leader_c;
  logic                      correct_d, hit_c, judged_d, game_over_d, busy_d;
  logic [SUM_W-1:0]          sum;
  logic signed [CMP_W-1:0]   lhs, rhs;

  function automatic logic signed [SCORE_W-1:0] sat(input logic signed [EXT_W-1:0] v);
    if (v > SAT_HI) return SCORE_W'(SAT_HI);
    if (v < SAT_LO) return SCORE_W'(SAT_LO);
    return SCORE_W'(v);
  endfunction

  rr_arbiter #(.N(N_PLAYERS)) u_arb (
    .req (bell_req),
    .ptr (ptr),
    .gnt (gnt_c)
  );

  for (genvar i = 0; i < int'(N_PLAYERS); i++) begin : g_score
    assign score[i*SCORE_W +: SCORE_W] = score_q[i];
  end

  // A bell is right when any single colour's visible fruit totals TARGET.
  always_comb begin
    hit_c = 1'b0;
    sum   = '0;
    for (int c = 0; c < int'(N_COLORS); c++) begin
      sum = '0;
      for (int p = 0; p < int'(N_PLAYERS); p++) begin
        if (card_color[p*COLOR_W +: COLOR_W] == COLOR_W'(c) &&
            card_num[p*NUM_W +: NUM_W] != '0)
          sum = sum + SUM_W'(card_num[p*NUM_W +: NUM_W]);
      end
      if (sum == SUM_W'(TARGET)) hit_c = 1'b1;
    end
  end

  always_comb begin
    gidx_c = '0;
    for (int i = 0; i < int'(N_PLAYERS); i++)
      if (gnt_c[i]) gidx_c = PTR_W'(i);
  end

  // Leader needs a WIN_MARGIN lead over everyone; one extra bit avoids overflow.
  always_comb begin
    leader_c = '0;
    lhs      = '0;
    rhs      = '0;
    for (int i = 0; i < int'(N_PLAYERS); i++) begin
      leader_c[i] = 1'b1;
      for (int j = 0; j < int'(N_PLAYERS); j++) begin
        if (j != i) begin
          lhs = CMP_W'(score_q[i]);
          rhs = CMP_W'(score_q[j]) + MARGIN;
          if (lhs < rhs) leader_c[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    lock_d      = lock_cnt;
    gidx_d      = gidx;
    grant_d     = grant;
    correct_d   = correct;
    pot_d       = pot_q;
    judged_d    = 1'b0;
    game_over_d = game_over;
    score_d     = score_q;
    case (state)
      IDLE: begin
        if (!game_over && (|bell_req)) begin
          grant_d   = gnt_c;
          gidx_d    = gidx_c;
          correct_d = hit_c;
          pot_d     = pot;
          ptr_d     = (gidx_c == PTR_W'(N_PLAYERS - 1)) ? '0 : gidx_c + PTR_W'(1);
          state_d   = JUDGE;
        end
      end
      JUDGE: begin
        for (int i = 0; i < int'(N_PLAYERS); i++) begin
          if (correct) begin
            if (PTR_W'(i) == gidx)
              score_d[i] = sat(EXT_W'(score_q[i]) + $signed({2'b00, pot_q}));
          end else if (PTR_W'(i) == gidx) begin
            score_d[i] = sat(EXT_W'(score_q[i]) - ONE);
          end else begin
            score_d[i] = sat(EXT_W'(score_q[i]) + ONE);
          end
        end
        judged_d = 1'b1;
        lock_d   = '0;
        state_d  = LOCKOUT;
      end
      LOCKOUT: begin
        // lock_cnt counts LOCKOUT cycles already completed before this one.
        if (|leader) begin
          game_over_d = 1'b1;
          state_d     = DONE;
        end else if (lock_cnt >= LOCK_W'(LOCK_CYC - 1) && bell_req == '0) begin
          state_d = IDLE;
        end else if (lock_cnt < LOCK_W'(LOCK_CYC - 1)) begin
          lock_d = lock_cnt + LOCK_W'(1);
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      lock_cnt  <= '0;
      gidx      <= '0;
      pot_q     <= '0;
      grant     <= '0;
      correct   <= 1'b0;
      judged    <= 1'b0;
      leader    <= '0;
      game_over <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(N_PLAYERS); i++) score_q[i] <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      lock_cnt  <= lock_d;
      gidx      <= gidx_d;
      pot_q     <= pot_d;
      grant     <= grant_d;
      correct   <= correct_d;
      judged    <= judged_d;
      leader    <= leader_c;
      game_over <= game_over_d;
      busy      <= busy_d;
      score_q   <= score_d;
    end
  end

endmodule

// File: doc/multi_bell_judge.md
MULTI_BELL_JUDGE -- requirements
Module: multi_bell_judge

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 4, giving the number of players (2..8).
REQ-002 SHALL have parameter SCORE_W, default 8, giving the signed two's-complement score width.
REQ-003 SHALL have parameter COLOR_W, default 2, giving the card colour code width.
REQ-004 SHALL have parameter NUM_W, default 3, giving the card fruit-count width (0 = empty pile).
REQ-005 SHALL have parameter TARGET, default 5, giving the winning same-colour fruit total.
REQ-006 SHALL have parameter WIN_MARGIN, default 10, giving the lead needed to declare a leader.
REQ-007 SHALL have parameter LOCK_CYC, default 4, giving the minimum lockout length in cycles.
REQ-008 SHALL have ports as listed: clk in 1, rising-edge clock; rst in 1, reset, synchronous, active-low.
REQ-009 SHALL have ports as listed: bell_req in N_PLAYERS, level per player, bit i = player i.
REQ-010 SHALL have ports as listed: card_color in N_PLAYERS*COLOR_W, top card colour per player; card_num in N_PLAYERS*NUM_W, top card count per player.
REQ-011 SHALL have ports as listed: pot in SCORE_W, unsigned cards in middle.
REQ-012 SHALL have ports as listed: score out N_PLAYERS*SCORE_W, signed per-player totals; grant out N_PLAYERS, one-hot presser of last round.
REQ-013 SHALL have ports as listed: judged out 1, one-cycle pulse at score update; correct out 1, result of last round.
REQ-014 SHALL have ports as listed: leader out N_PLAYERS, one-hot leading player or zero; game_over out 1, sticky; busy out 1, high when state is not IDLE.

Function
REQ-015 SHALL define a bell as correct when, for some colour c, the sum of card_num over players with card_color==c and card_num!=0 equals TARGET, using a sum width of clog2(N_PLAYERS*(2^NUM_W-1)+1).
REQ-016 SHALL implement FSM states IDLE, JUDGE, LOCKOUT, and DONE.
REQ-017 SHALL, in IDLE with game_over=0 and bell_req!=0, grant one player round-robin starting from pointer ptr, latch grant and correct from the cards of that same cycle, advance ptr to (granted index+1) mod N_PLAYERS, and go to JUDGE.
REQ-018 SHALL resolve simultaneous presses with only the round-robin winner; the other presses in that cycle are discarded.
REQ-019 SHALL, in JUDGE, update scores in one cycle, assert judged for exactly that following cycle, and go to LOCKOUT; latency from the press edge to the score change is 2 clocks.
REQ-020 SHALL, on a correct bell, set the granted score to granted score + pot.
REQ-021 SHALL, on a wrong bell, set the granted score to granted score - 1 and every other player's score to that score + 1.
REQ-022 SHALL saturate all score arithmetic at the signed limits (+2^(SCORE_W-1)-1, -2^(SCORE_W-1)), with no wrap-around.
REQ-023 SHALL ignore bell_req throughout JUDGE and LOCKOUT.
REQ-024 SHALL leave LOCKOUT for IDLE only after at least LOCK_CYC cycles in LOCKOUT with bell_req==0 in the same cycle; a held button extends the lockout.
REQ-025 SHALL register leader each cycle: bit i is set iff score_i >= score_j + WIN_MARGIN for all j!=i, evaluated signed with one extra bit to avoid overflow.
REQ-026 SHALL, when leader becomes nonzero while in LOCKOUT, set game_over and go to DONE; DONE ignores all input until reset.
REQ-027 SHALL hold grant and correct stable from the JUDGE cycle until the next grant.
REQ-028 SHALL ignore pot and card inputs outside the grant cycle.

Reset
REQ-029 SHALL, on rst=0 at a clock edge and regardless of state (including mid-JUDGE or mid-LOCKOUT), set state to IDLE, ptr to 0, lockout counter to 0, all scores to 0, and grant, judged, correct, leader, game_over, and busy to 0.
REQ-030 SHALL, on the first cycle after reset release, accept a bell in IDLE.

Structure
REQ-031 SHALL place the FSM state enumeration and the default parameter constants in the shared package bell_pkg.
REQ-032 SHALL implement the round-robin grant as sub-module rr_arbiter (parameter N; inputs req and ptr; output one-hot gnt).
REQ-033 SHALL keep the correctness evaluation, score file, and leader compare in multi_bell_judge.

Verification
REQ-034 SHALL verify that with N=4, cards (red,2)(red,3)(green,1)(blue,4), pot=12, and P2 pressing, scores become {0,0,12,0}, correct=1, grant=0100, and judged pulses 2 clocks after the press.
REQ-035 SHALL verify that with cards (red,2)(green,2)(blue,1)(red,4) and P0 pressing, scores become {-1,+1,+1,+1} and correct=0.
REQ-036 SHALL verify that with P1 and P3 pressing in the same cycle and ptr=2, P3 is granted, ptr becomes 0, and P1 is unscored.
REQ-037 SHALL verify that with P0 holding bell_req for 10 cycles after a round, the state stays LOCKOUT until release plus no earlier than LOCK_CYC, and no second grant occurs.
REQ-038 SHALL verify that with P0 at 120 and pot=20 on a correct bell, score saturates at 127, leader=0001, and game_over=1.
REQ-039 SHALL verify that asserting rst=0 during LOCKOUT gives all scores 0, busy=0, and an accepted bell on the next cycle.
